// File: rtl/spm_ex_dma.sv
// Burst initiator for the scratchpad external port: streams writes into one bank
// group, or reads consecutive words back through a small return FIFO.
module spm_ex_dma #(
  parameter int A_W        = 8,
  parameter int D_W        = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       park_bg,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_bg,
  input  logic [A_W-1:0]   cmd_addr,
  input  logic [A_W:0]     cmd_len,
  input  logic [D_W-1:0]   wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [D_W-1:0]   rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             done,
  output logic [A_W+35:0]  ex_in_bus,
  input  logic [D_W-1:0]   ex_out_bus
);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_e;

  state_e          state_q, state_d;
  logic [1:0]      bg_q, bg_d;
  logic [A_W-1:0]  cur_q, cur_d;
  logic [A_W:0]    rem_q, rem_d;
  logic [A_W:0]    prem_q, prem_d;
  logic            was_rd_q, was_rd_d;
  logic            done_q, done_d;
  logic [1:0]      wsel_q, wsel_d, rsel_q, rsel_d;
  logic [A_W-1:0]  addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [RD_LAT:0] vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d, inflight;
  logic [D_W:0]    mem_q [FIFO_DEPTH];
  logic            push, pop, beat, iss, drain_exit;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  assign push       = vld_pipe_q[RD_LAT];
  assign rd_valid   = (cnt_q != '0);
  assign pop        = rd_valid && rd_ready;
  assign cmd_ready  = (state_q == IDLE);
  assign wr_ready   = (state_q == WRITE) && (rem_q != '0);
  assign beat       = wr_valid && wr_ready;
  // A pop this cycle frees a slot, so it counts as credit for a new issue.
  assign iss        = (state_q == READ) && (rem_q != '0) &&
                      ((cnt_q + inflight) < (CW'(FIFO_DEPTH) + CW'(pop)));
  assign drain_exit = (state_q == DRAIN) && (inflight == '0) && (cnt_q == CW'(1)) && pop;

  assign rd_data   = mem_q[rp_q][D_W-1:0];
  assign rd_last   = rd_valid && mem_q[rp_q][D_W];
  assign done      = done_q;
  assign ex_in_bus = {wsel_q, rsel_q, addr_q, data_q};

  always_comb begin
    state_d    = state_q;
    bg_d       = bg_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    prem_d     = prem_q;
    was_rd_d   = was_rd_q;
    done_d     = 1'b0;
    wsel_d     = park_bg;
    rsel_d     = rsel_q;
    addr_d     = addr_q;
    data_d     = data_q;
    vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], iss};
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: if (cmd_valid) begin
        bg_d     = cmd_bg;
        cur_d    = cmd_addr;
        rem_d    = cmd_len;
        prem_d   = cmd_len;
        was_rd_d = cmd_dir && (cmd_len != '0);
        if (cmd_len == '0) state_d = FIN;
        else if (cmd_dir) begin
          state_d = READ;
          rsel_d  = cmd_bg;
        end else state_d = WRITE;
      end
      WRITE: if (beat) begin
        wsel_d = bg_q;
        addr_d = cur_q;
        data_d = 32'(wr_data);
        cur_d  = cur_q + A_W'(1);
        rem_d  = rem_q - (A_W+1)'(1);
        if (rem_q == (A_W+1)'(1)) state_d = FIN;
      end
      READ: if (iss) begin
        addr_d = cur_q;
        cur_d  = cur_q + A_W'(1);
        rem_d  = rem_q - (A_W+1)'(1);
        if (rem_q == (A_W+1)'(1)) state_d = DRAIN;
      end
      DRAIN: if (drain_exit) begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN: begin
        // Read bursts already pulsed done on the final pop.
        done_d  = !was_rd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      wp_d   = (wp_q == PW'(FIFO_DEPTH-1)) ? '0 : wp_q + PW'(1);
      prem_d = prem_q - (A_W+1)'(1);
    end
    if (pop) rp_d = (rp_q == PW'(FIFO_DEPTH-1)) ? '0 : rp_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bg_q       <= '0;
      cur_q      <= '0;
      rem_q      <= '0;
      prem_q     <= '0;
      was_rd_q   <= 1'b0;
      done_q     <= 1'b0;
      wsel_q     <= '0;
      rsel_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      vld_pipe_q <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bg_q       <= bg_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      prem_q     <= prem_d;
      was_rd_q   <= was_rd_d;
      done_q     <= done_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      vld_pipe_q <= vld_pipe_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage is not reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {prem_q == (A_W+1)'(1), ex_out_bus};
  end
endmodule
